// File: rtl/imem_arbiter.sv
// Arbitrates one single-port instruction memory between CPU fetch and a program loader.
// Latency: grant is combinational in the request cycle; fetch_valid / load_ack follow one cycle later.
// Backpressure: the losing fetch sees fetch_stall; the loader holds load_req until load_grant.
module imem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [15:0] fetch_addr,
   output logic        fetch_stall,
   output logic [15:0] fetch_data,
   output logic        fetch_valid,
   input  logic        load_req,
   input  logic        load_we,
   input  logic [15:0] load_addr,
   input  logic [15:0] load_wdata,
   output logic        load_grant,
   output logic        load_ack,
   output logic [15:0] load_rdata,
   output logic        load_err,
   input  logic        load_lock,
   output logic        cpu_halt,
   output logic [12:0] mem_addr,
   output logic        mem_we,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, DRAIN, LOCKED, RELEASE} state_t;

   state_t      state, stateNext;
   logic [2:0]  wcnt;
   logic        grantF, grantL;
   logic        loadInRange;
   logic [12:0] addrHold;
   logic        fetchValidQ, loadAckQ, loadErrQ, loadReadQ, cpuHaltQ;

   assign loadInRange = (load_addr[15:13] == 3'b000);

   // Next-state and grant selection; fetch only ever wins in IDLE, and never under reset.
   always_comb begin
      stateNext = state;
      grantF    = 1'b0;
      grantL    = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               grantL = load_req && ((wcnt == 3'd4) || !fetch_req);
               grantF = fetch_req && !grantL;
               if (load_lock) stateNext = DRAIN;
            end
            DRAIN: begin
               grantL    = load_req;
               stateNext = LOCKED;
            end
            LOCKED: begin
               grantL = load_req;
               if (!load_lock) stateNext = RELEASE;
            end
            RELEASE: begin
               grantL    = load_req;
               stateNext = IDLE;
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   // Memory port mux; the address parks on the last issued access when nobody is granted.
   always_comb begin
      fetch_stall = fetch_req && !grantF && !rst;
      load_grant  = grantL;
      if (grantL)      mem_addr = load_addr[12:0];
      else if (grantF) mem_addr = fetch_addr[12:0];
      else             mem_addr = addrHold;
      mem_we      = grantL && load_we && loadInRange;
      mem_wdata   = load_wdata;
   end

   // Response outputs; masking with rst drops any response whose grant preceded a reset.
   always_comb begin
      fetch_valid = fetchValidQ && !rst;
      fetch_data  = fetch_valid ? mem_rdata : 16'h0000;
      load_ack    = loadAckQ && !rst;
      load_err    = loadErrQ && !rst;
      load_rdata  = (load_ack && loadReadQ) ? mem_rdata : 16'h0000;
      cpu_halt    = cpuHaltQ;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // Loader starvation counter: counts cycles a pending loader request loses, saturating at 4.
   always_ff @(posedge clk) begin
      if (rst || (state == LOCKED) || grantL || !load_req) wcnt <= 3'd0;
      else if (wcnt != 3'd4)                               wcnt <= wcnt + 3'd1;
   end

   // Response tracking for the access issued this cycle, plus registered halt.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetchValidQ <= 1'b0;
         loadAckQ    <= 1'b0;
         loadErrQ    <= 1'b0;
         loadReadQ   <= 1'b0;
         cpuHaltQ    <= 1'b0;
         addrHold    <= 13'd0;
      end else begin
         fetchValidQ <= grantF;
         loadAckQ    <= grantL;
         loadErrQ    <= grantL && !loadInRange;
         loadReadQ   <= grantL && !load_we && loadInRange;
         cpuHaltQ    <= (stateNext != IDLE);
         if (grantL || grantF) addrHold <= mem_addr;
      end
   end

endmodule
